nibble_link_host: RTL and testbench

Host-side initiator for the 12-bit nibble link into the arithmetic chip. It accepts one operation request (two 16-bit operands plus an add/mul select) on a valid/ready port and serialises it into a nibble frame on link_out. It then captures the two-byte result returned on link_in and presents the reassembled 16-bit result, or a timeout error, on a valid/ready response port. It sits in the board/bench wrapper that drives the chip pins.

---
 rtl/nibble_link_pkg.sv | 49 ++++
 rtl/nibble_link_host_frame_tx.sv | 59 +++++
 rtl/nibble_link_host.sv | 181 ++++++++++++++++++
 tb/tb_nibble_link_host.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_link_pkg.sv
// Shared types, link bit positions and the frame beat encoder for the
// host side of the 12-bit nibble link.
package nibble_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CAP_HI = 3'd3,
    ST_RESP   = 3'd4,
    ST_GAP    = 3'd5
  } link_state_e;

  localparam int FRAME_BEATS = 6;
  localparam int DATA_BEATS  = 4;
  localparam int LINK_W      = 12;
  localparam int LINK_EN     = 9;
  localparam int LINK_OP     = 8;
  localparam int NIB_A_LSB   = 0;
  localparam int NIB_B_LSB   = 4;
  localparam int RES_VALID   = 8;

  // Link word for one SEND beat; beats past the data beats are commit beats with zero data.
  function automatic logic [LINK_W-1:0] frame_word(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        op,
    input logic [2:0]  beat
  );
    logic [LINK_W-1:0] w;
    w          = 12'h000;
    w[LINK_EN] = 1'b1;
    w[LINK_OP] = op;
    if (beat < 3'(DATA_BEATS)) begin
      case (beat[1:0])
        2'd0: begin w[NIB_A_LSB +: 4] = a[3:0];   w[NIB_B_LSB +: 4] = b[3:0];   end
        2'd1: begin w[NIB_A_LSB +: 4] = a[7:4];   w[NIB_B_LSB +: 4] = b[7:4];   end
        2'd2: begin w[NIB_A_LSB +: 4] = a[11:8];  w[NIB_B_LSB +: 4] = b[11:8];  end
        2'd3: begin w[NIB_A_LSB +: 4] = a[15:12]; w[NIB_B_LSB +: 4] = b[15:12]; end
        default: begin w[NIB_A_LSB +: 4] = 4'h0;  w[NIB_B_LSB +: 4] = 4'h0;     end
      endcase
    end else begin
      w[NIB_A_LSB +: 4] = 4'h0;
      w[NIB_B_LSB +: 4] = 4'h0;
    end
    return w;
  endfunction

endpackage

// File: rtl/nibble_link_host_frame_tx.sv
// Beat counter and nibble mux for the SEND phase. The word presented is the one
// for the NEXT cycle, so the host can register it straight onto link_out.
module nibble_frame_tx
  import nibble_link_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       a,
  input  logic [15:0]       b,
  input  logic              op,
  output logic [LINK_W-1:0] word,
  output logic              done
);

  logic [2:0] beat_r;
  logic       active_r;
  logic [2:0] idx_s;

  assign done = active_r && (beat_r == 3'(FRAME_BEATS - 1));

  // Select which beat the next registered link word should carry.
  always_comb begin
    idx_s = 3'd0;
    if (start) begin
      idx_s = 3'd0;
    end else begin
      idx_s = beat_r + 3'd1;
    end
  end

  // Nibble mux for the selected beat.
  always_comb begin
    word = frame_word(a, b, op, idx_s);
  end

  // Beat counter; it only wraps when the frame ends.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_r   <= 3'd0;
      active_r <= 1'b0;
    end else if (start) begin
      beat_r   <= 3'd0;
      active_r <= 1'b1;
    end else if (active_r) begin
      if (done) begin
        beat_r   <= 3'd0;
        active_r <= 1'b0;
      end else begin
        beat_r   <= beat_r + 3'd1;
        active_r <= 1'b1;
      end
    end else begin
      beat_r   <= beat_r;
      active_r <= active_r;
    end
  end

endmodule

// File: rtl/nibble_link_host.sv
// Host initiator for the nibble link: sends one operation frame, collects the
// two-byte result (or times out) and offers it on a valid/ready response port.
module nibble_link_host
  import nibble_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_error,
  output logic [11:0] link_out,
  input  logic [8:0]  link_in
);

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  link_state_e       state_r, state_s;
  logic [15:0]       opnd_a_r, opnd_a_s;
  logic [15:0]       opnd_b_r, opnd_b_s;
  logic              op_r, op_s;
  logic [9:0]        tmo_cnt_r, tmo_cnt_s;
  logic [3:0]        gap_cnt_r, gap_cnt_s;
  logic [7:0]        res_lo_r, res_lo_s;
  logic [15:0]       resp_data_r, resp_data_s;
  logic              resp_error_r, resp_error_s;
  logic              resp_valid_r, resp_valid_s;
  logic              req_ready_r, req_ready_s;
  logic [LINK_W-1:0] link_r, link_s;
  logic              accept_s;
  logic              tx_start_s;
  logic              tx_done_s;
  logic [LINK_W-1:0] tx_word_s;

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_error = resp_error_r;
  assign link_out   = link_r;

  nibble_frame_tx u_frame_tx (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (tx_start_s),
    .a       (opnd_a_s),
    .b       (opnd_b_s),
    .op      (op_s),
    .word    (tx_word_s),
    .done    (tx_done_s)
  );

  // Next-state, capture/timeout bookkeeping and next registered output values.
  always_comb begin
    state_s      = state_r;
    opnd_a_s     = opnd_a_r;
    opnd_b_s     = opnd_b_r;
    op_s         = op_r;
    tmo_cnt_s    = tmo_cnt_r;
    gap_cnt_s    = gap_cnt_r;
    res_lo_s     = res_lo_r;
    resp_data_s  = resp_data_r;
    resp_error_s = resp_error_r;
    tx_start_s   = 1'b0;
    link_s       = 12'h000;
    accept_s     = req_valid & req_ready_r;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          opnd_a_s   = req_a;
          opnd_b_s   = req_b;
          op_s       = req_op;
          tx_start_s = 1'b1;
          state_s    = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (tx_done_s) begin
          tmo_cnt_s = 10'd0;
          state_s   = ST_WAIT;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_WAIT: begin
        // A result arriving on the expiry cycle still wins over the timeout.
        if (link_in[RES_VALID]) begin
          res_lo_s = link_in[7:0];
          state_s  = ST_CAP_HI;
        end else if (tmo_cnt_r == TMO_LAST) begin
          resp_data_s  = 16'h0000;
          resp_error_s = 1'b1;
          state_s      = ST_RESP;
        end else if (tmo_cnt_r != 10'h3FF) begin
          tmo_cnt_s = tmo_cnt_r + 10'd1;
          state_s   = ST_WAIT;
        end else begin
          tmo_cnt_s = tmo_cnt_r;
          state_s   = ST_WAIT;
        end
      end
      ST_CAP_HI: begin
        resp_data_s  = {link_in[7:0], res_lo_r};
        resp_error_s = 1'b0;
        state_s      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          gap_cnt_s = 4'd0;
          state_s   = ST_GAP;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s = ST_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + 4'd1;
          state_s   = ST_GAP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    req_ready_s  = (state_s == ST_IDLE);
    resp_valid_s = (state_s == ST_RESP);

    // The chip samples the op select late, so it stays up until the response is taken.
    case (state_s)
      ST_SEND:                     link_s = tx_word_s;
      ST_WAIT, ST_CAP_HI, ST_RESP: link_s[LINK_OP] = op_s;
      default:                     link_s = 12'h000;
    endcase
  end

  // State and output registers; reset drops any frame in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      opnd_a_r     <= 16'h0000;
      opnd_b_r     <= 16'h0000;
      op_r         <= 1'b0;
      tmo_cnt_r    <= 10'd0;
      gap_cnt_r    <= 4'd0;
      res_lo_r     <= 8'h00;
      resp_data_r  <= 16'h0000;
      resp_error_r <= 1'b0;
      resp_valid_r <= 1'b0;
      req_ready_r  <= 1'b0;
      link_r       <= 12'h000;
    end else begin
      state_r      <= state_s;
      opnd_a_r     <= opnd_a_s;
      opnd_b_r     <= opnd_b_s;
      op_r         <= op_s;
      tmo_cnt_r    <= tmo_cnt_s;
      gap_cnt_r    <= gap_cnt_s;
      res_lo_r     <= res_lo_s;
      resp_data_r  <= resp_data_s;
      resp_error_r <= resp_error_s;
      resp_valid_r <= resp_valid_s;
      req_ready_r  <= req_ready_s;
      link_r       <= link_s;
    end
  end

endmodule

// File: tb/tb_nibble_link_host.sv
// Randomized bench for nibble_link_host with a transaction-level model of the
// link frame, the chip's reply timing, the timeout rule and the gap spacing.
module tb_nibble_link_host;

  localparam int TMO = 20;
  localparam int GAP = 3;
  localparam int N   = 18;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_a = 16'h0000;
  logic [15:0] req_b = 16'h0000;
  logic        req_op = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_data;
  logic        resp_error;
  logic [11:0] link_out;
  logic [8:0]  link_in = 9'h000;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] ta [N];
  logic [15:0] tb [N];
  logic        topr [N];
  int          tlat [N];
  int          tbp [N];
  bit          tb2b [N];

  always #5 clock = ~clock;

  nibble_link_host #(.TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_error (resp_error),
    .link_out   (link_out),
    .link_in    (link_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Frame beat k: nibble k of each operand while k < 4, zero data afterwards.
  function automatic logic [11:0] exp_frame(logic [15:0] a, logic [15:0] b, logic op, int k);
    logic [3:0] na, nb;
    if (k < 4) begin
      na = 4'((a >> (4 * k)) & 16'h000F);
      nb = 4'((b >> (4 * k)) & 16'h000F);
    end else begin
      na = 4'h0;
      nb = 4'h0;
    end
    return {2'b00, 1'b1, op, nb, na};
  endfunction

  function automatic logic [15:0] chip_result(logic [15:0] a, logic [15:0] b, logic op);
    logic [31:0] p;
    p = op ? (32'(a) + 32'(b)) : (32'(a) * 32'(b));
    return p[15:0];
  endfunction

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic op);
    int waited;
    waited = 0;
    while (!req_ready && waited < 60) begin
      tick();
      waited++;
    end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
    tick();
    req_valid = 1'b0; req_a = 16'($urandom); req_b = 16'($urandom); req_op = 1'($urandom);
  endtask

  task automatic run_txn(input int i);
    logic [15:0] a, b, res, exp_data;
    logic        op, exp_err;
    a = ta[i]; b = tb[i]; op = topr[i];
    accept(a, b, op);
    for (int k = 0; k < 6; k++) begin
      link_in = (k == 2 || k == 3) ? {1'b1, 8'($urandom)} : 9'h000;
      chk("frame_beat", 32'(link_out), 32'(exp_frame(a, b, op, k)));
      chk("ready_low_send", 32'(req_ready), 32'd0);
      tick();
    end
    link_in = 9'h000;
    chk("wait_link", 32'(link_out), op ? 32'h100 : 32'h000);
    res = chip_result(a, b, op);
    if (tlat[i] < TMO) begin
      for (int j = 0; j < tlat[i]; j++) begin
        chk("no_early_resp", 32'(resp_valid), 32'd0);
        link_in = {1'b0, 8'($urandom)};
        tick();
      end
      link_in = {1'b1, res[7:0]};
      tick();
      link_in = {1'b1, res[15:8]};
      tick();
      link_in = 9'h000;
      exp_data = res; exp_err = 1'b0;
    end else begin
      for (int j = 0; j < TMO; j++) begin
        chk("no_early_resp", 32'(resp_valid), 32'd0);
        tick();
      end
      exp_data = 16'h0000; exp_err = 1'b1;
    end
    for (int j = 0; j <= tbp[i]; j++) begin
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_data", 32'(resp_data), 32'(exp_data));
      chk("resp_error", 32'(resp_error), 32'(exp_err));
      chk("ready_low_resp", 32'(req_ready), 32'd0);
      chk("resp_link", 32'(link_out), op ? 32'h100 : 32'h000);
      if (j == tbp[i]) resp_ready = 1'b1;
      tick();
    end
    resp_ready = 1'b0;
    for (int g = 0; g < GAP; g++) begin
      chk("gap_no_resp", 32'(resp_valid), 32'd0);
      chk("gap_ready", 32'(req_ready), 32'd0);
      chk("gap_link", 32'(link_out), 32'h000);
      link_in = {1'b1, 8'($urandom)};
      if (tb2b[i] && i + 1 < N) begin
        req_valid = 1'b1; req_a = ta[i+1]; req_b = tb[i+1]; req_op = topr[i+1];
      end
      tick();
    end
    link_in = 9'h000;
    chk("ready_after_gap", 32'(req_ready), 32'd1);
    chk("idle_link", 32'(link_out), 32'h000);
  endtask

  task automatic reset_mid(input bit in_wait);
    accept(16'hBEEF, 16'hCAFE, 1'b1);
    if (in_wait) begin
      for (int k = 0; k < 9; k++) tick();
      chk("pre_reset_wait_link", 32'(link_out), 32'h100);
    end else begin
      for (int k = 0; k < 3; k++) tick();
      chk("pre_reset_beat3", 32'(link_out), 32'(exp_frame(16'hBEEF, 16'hCAFE, 1'b1, 3)));
    end
    #2 reset_n = 1'b0;
    #1;
    chk("rst_link", 32'(link_out), 32'h000);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_link", 32'(link_out), 32'h000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ta[0] = 16'h1234; tb[0] = 16'h0005; topr[0] = 1'b1; tlat[0] = 0;       tbp[0] = 0; tb2b[0] = 1'b0;
    ta[1] = 16'h0010; tb[1] = 16'h0003; topr[1] = 1'b0; tlat[1] = 1;       tbp[1] = 5; tb2b[1] = 1'b0;
    for (int i = 2; i < N; i++) begin
      ta[i] = 16'($urandom); tb[i] = 16'($urandom); topr[i] = 1'($urandom);
      tlat[i] = int'($urandom_range(0, TMO + 2));
      tbp[i]  = int'($urandom_range(0, 3));
      tb2b[i] = 1'($urandom_range(0, 1));
    end
    tlat[2] = TMO;     tbp[2] = 2;
    tlat[3] = TMO - 1; tbp[3] = 0;
    tb2b[4] = 1'b1;
    tb2b[N-1] = 1'b0;

    #3;
    chk("reset_link", 32'(link_out), 32'h000);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("first_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < N; i++) run_txn(i);
    reset_mid(1'b0);
    reset_mid(1'b1);
    run_txn(0);
    run_txn(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
